// File: rtl/obuf_bank.sv
// obuf_bank: output-row buffer with a 1-cycle systolic read port and a valid/ready drain streamer.
// Ports:
//   clk, reset (async, active-low)
//   obuf_write_req/addr/data            : row write-back
//   obuf_read_req/addr -> obuf_read_data/valid : systolic read, fixed 1-cycle latency, top priority
//   drain_start/base/count              : launch a drain of count rows from base (wraps modulo depth)
//   drain_valid/ready/data              : drained row stream
//   drain_busy, drain_done              : drain in progress / one-cycle completion pulse
module obuf_bank #(
  parameter int ARRAY_M         = 4,
  parameter int ACC_WIDTH       = 48,
  parameter int OUT_WIDTH       = ARRAY_M * ACC_WIDTH,
  parameter int OBUF_ADDR_WIDTH = 16,
  parameter int OBUF_DEPTH_LOG2 = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       obuf_write_req,
  input  logic [OBUF_ADDR_WIDTH-1:0] obuf_write_addr,
  input  logic [OUT_WIDTH-1:0]       obuf_write_data,
  input  logic                       obuf_read_req,
  input  logic [OBUF_ADDR_WIDTH-1:0] obuf_read_addr,
  output logic [OUT_WIDTH-1:0]       obuf_read_data,
  output logic                       obuf_read_valid,
  input  logic                       drain_start,
  input  logic [OBUF_ADDR_WIDTH-1:0] drain_base,
  input  logic [OBUF_ADDR_WIDTH-1:0] drain_count,
  output logic                       drain_busy,
  output logic                       drain_valid,
  input  logic                       drain_ready,
  output logic [OUT_WIDTH-1:0]       drain_data,
  output logic                       drain_done
);
  localparam int DEPTH = 2 ** OBUF_DEPTH_LOG2;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_next;
  logic [OUT_WIDTH-1:0] mem [DEPTH];
  logic [OUT_WIDTH-1:0] rd_q;
  logic [OBUF_DEPTH_LOG2-1:0] wa, ra, ptr;
  logic [OBUF_ADDR_WIDTH-1:0] remaining;
  logic pending, issue, accept, finish, launch;
  logic unused_addr_bits;
  assign wa = obuf_write_addr[OBUF_DEPTH_LOG2-1:0];
  assign ra = obuf_read_addr[OBUF_DEPTH_LOG2-1:0];
  assign unused_addr_bits = ^{obuf_write_addr[OBUF_ADDR_WIDTH-1:OBUF_DEPTH_LOG2],
                              obuf_read_addr[OBUF_ADDR_WIDTH-1:OBUF_DEPTH_LOG2],
                              drain_base[OBUF_ADDR_WIDTH-1:OBUF_DEPTH_LOG2]};
  assign drain_busy = state == RUN;
  // Storage and the drain-side read stage; both reads forward a same-cycle write to the same row.
  always_ff @(posedge clk) begin
    if (obuf_write_req) mem[wa] <= obuf_write_data;
    if (issue) rd_q <= (obuf_write_req && wa == ptr) ? obuf_write_data : mem[ptr];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end
  always_comb begin
    state_next = state;
    accept     = drain_valid & drain_ready;
    launch     = 1'b0;
    issue      = 1'b0;
    finish     = 1'b0;
    if (state == IDLE) begin
      launch     = drain_start;
      state_next = (drain_start && drain_count != '0) ? RUN : IDLE;
    end else begin
      // One outstanding drain read at a time, and the systolic port always wins the RAM.
      issue      = remaining != '0 && !obuf_read_req && !pending && (!drain_valid || accept);
      finish     = remaining == '0 && !pending && accept;
      state_next = finish ? IDLE : RUN;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      obuf_read_data  <= '0;
      obuf_read_valid <= 1'b0;
      drain_data      <= '0;
      drain_valid     <= 1'b0;
      drain_done      <= 1'b0;
      pending         <= 1'b0;
      ptr             <= '0;
      remaining       <= '0;
    end else begin
      obuf_read_valid <= obuf_read_req;
      if (obuf_read_req) obuf_read_data <= (obuf_write_req && wa == ra) ? obuf_write_data : mem[ra];
      drain_done <= (launch && drain_count == '0) || finish;
      pending    <= issue;
      if (launch) begin
        ptr       <= drain_base[OBUF_DEPTH_LOG2-1:0];
        remaining <= drain_count;
      end
      if (issue) begin
        ptr       <= ptr + 1'b1;
        remaining <= remaining - 1'b1;
      end
      if (pending) begin
        drain_data  <= rd_q;
        drain_valid <= 1'b1;
      end else if (accept) drain_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_obuf_bank.sv
// tb_obuf_bank: directed bench for obuf_bank with a queue/array reference model checked every cycle.
module tb_obuf_bank;
  localparam int W  = 192;
  localparam int AW = 16;
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          obuf_write_req = 1'b0;
  logic [AW-1:0] obuf_write_addr = '0;
  logic [W-1:0]  obuf_write_data = '0;
  logic          obuf_read_req = 1'b0;
  logic [AW-1:0] obuf_read_addr = '0;
  logic [W-1:0]  obuf_read_data;
  logic          obuf_read_valid;
  logic          drain_start = 1'b0;
  logic [AW-1:0] drain_base = '0;
  logic [AW-1:0] drain_count = '0;
  logic          drain_busy;
  logic          drain_valid;
  logic          drain_ready = 1'b0;
  logic [W-1:0]  drain_data;
  logic          drain_done;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  obuf_bank dut (
    .clk(clk), .reset(reset),
    .obuf_write_req(obuf_write_req), .obuf_write_addr(obuf_write_addr), .obuf_write_data(obuf_write_data),
    .obuf_read_req(obuf_read_req), .obuf_read_addr(obuf_read_addr),
    .obuf_read_data(obuf_read_data), .obuf_read_valid(obuf_read_valid),
    .drain_start(drain_start), .drain_base(drain_base), .drain_count(drain_count),
    .drain_busy(drain_busy), .drain_valid(drain_valid), .drain_ready(drain_ready),
    .drain_data(drain_data), .drain_done(drain_done)
  );
  task automatic chk(input string nm, input logic [W-1:0] a, input logic [W-1:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, a, e);
    end
  endtask
  function automatic logic [W-1:0] row(input logic [47:0] v);
    return {4{v}};
  endfunction
  // Reference model: plain memory array plus a queue of rows a drain must deliver.
  logic [W-1:0]  m [1024];
  logic [W-1:0]  q [$];
  logic [W-1:0]  exp_rd = '0;
  logic [W-1:0]  pv_ddata = '0;
  logic [W-1:0]  c_wd, w;
  logic [AW-1:0] c_wa, c_ra, c_base, c_cnt;
  logic          c_wreq, c_rreq, c_start, c_ready, pv_dvalid = 1'b0;
  bit            active = 0, was_active, done_e;
  initial begin
    for (int i = 0; i < 1024; i++) m[i] = '0;
    forever begin
      @(posedge clk);
      c_wreq = obuf_write_req; c_wa = obuf_write_addr; c_wd = obuf_write_data;
      c_rreq = obuf_read_req;  c_ra = obuf_read_addr;
      c_start = drain_start;   c_base = drain_base; c_cnt = drain_count; c_ready = drain_ready;
      #1;
      if (!reset) begin
        chk("rst_read_data", obuf_read_data, '0);
        chk("rst_read_valid", obuf_read_valid, '0);
        chk("rst_busy", drain_busy, '0);
        chk("rst_dvalid", drain_valid, '0);
        chk("rst_ddata", drain_data, '0);
        chk("rst_done", drain_done, '0);
        q.delete();
        active = 0; exp_rd = '0; pv_dvalid = 1'b0; pv_ddata = '0;
      end else begin
        done_e = 0;
        was_active = active;
        if (c_rreq) exp_rd = (c_wreq && c_wa[9:0] == c_ra[9:0]) ? c_wd : m[c_ra[9:0]];
        chk("m_read_data", obuf_read_data, exp_rd);
        chk("m_read_valid", obuf_read_valid, c_rreq);
        if (pv_dvalid && c_ready) begin
          if (q.size() == 0) chk("m_extra_word", 1, 0);
          else begin
            w = q.pop_front();
            chk("m_drain_word", pv_ddata, w);
            if (q.size() == 0) begin active = 0; done_e = 1; end
          end
        end else if (pv_dvalid) begin
          chk("m_stall_valid", drain_valid, 1);
          chk("m_stall_data", drain_data, pv_ddata);
        end
        if (c_start && !was_active) begin
          if (c_cnt == 0) done_e = 1;
          else begin
            active = 1;
            for (int i = 0; i < int'(c_cnt); i++) q.push_back(m[(int'(c_base) + i) % 1024]);
          end
        end
        chk("m_busy", drain_busy, active);
        chk("m_done", drain_done, done_e);
        if (!active) chk("m_idle_valid", drain_valid, 0);
        if (c_wreq) m[c_wa[9:0]] = c_wd;
        pv_dvalid = drain_valid; pv_ddata = drain_data;
      end
    end
  end
  logic [W-1:0] got [16];
  int got_n [16];
  int nw, first_n, done_n;
  // Called right after a negedge; counts n in cycles after the one carrying drain_start.
  task automatic run_drain(input logic [AW-1:0] base, input logic [AW-1:0] cnt, input int mode, input int max_words);
    int n;
    drain_start = 1'b1; drain_base = base; drain_count = cnt;
    @(negedge clk);
    drain_start = 1'b0;
    n = 1; nw = 0; first_n = -1; done_n = -1;
    while (n < 80 && done_n < 0 && nw < max_words) begin
      if (mode == 1) begin
        obuf_read_req = n[0]; obuf_read_addr = 16'd5;
        drain_ready = !(n >= 4 && n <= 6);
      end else drain_ready = 1'b1;
      if (drain_done) done_n = n;
      if (drain_valid && first_n < 0) first_n = n;
      if (drain_valid && drain_ready) begin got[nw] = drain_data; got_n[nw] = n; nw++; end
      if (done_n < 0 && nw < max_words) begin @(negedge clk); n++; end
    end
    obuf_read_req = 1'b0;
    if (n >= 80) chk("drain_timeout", 1, 0);
  endtask
  task automatic wr(input int a, input logic [W-1:0] d);
    obuf_write_req = 1'b1; obuf_write_addr = AW'(a); obuf_write_data = d;
    @(negedge clk);
    obuf_write_req = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("reset_valid", obuf_read_valid, 0);
    chk("reset_busy", drain_busy, 0);
    reset = 1'b1;
    @(negedge clk);
    wr(5, row(48'h1111));
    obuf_read_req = 1'b1; obuf_read_addr = 16'd5;
    @(negedge clk);
    obuf_read_req = 1'b0;
    chk("t1_data", obuf_read_data, row(48'h1111));
    chk("t1_valid", obuf_read_valid, 1);
    @(negedge clk);
    chk("t1_valid_drop", obuf_read_valid, 0);
    chk("t1_hold", obuf_read_data, row(48'h1111));
    wr(7, '0);
    obuf_write_req = 1'b1; obuf_write_addr = 16'd7; obuf_write_data = row(48'hABCD);
    obuf_read_req = 1'b1; obuf_read_addr = 16'd7;
    @(negedge clk);
    obuf_write_req = 1'b0; obuf_read_req = 1'b0;
    chk("t2_forward", obuf_read_data, row(48'hABCD));
    for (int i = 0; i < 4; i++) wr(i, row(48'(i + 1)));
    run_drain(16'd0, 16'd4, 0, 99);
    chk("t3_words", nw, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t3_data", got[i], row(48'(i + 1)));
      chk("t3_cycle", got_n[i], 3 + 2 * i);
    end
    chk("t3_first", first_n, 3);
    chk("t3_done", done_n, 10);
    chk("t3_busy_fall", drain_busy, 0);
    for (int i = 0; i < 4; i++) wr(8 + i, row(48'h10 + 48'(i)));
    run_drain(16'd8, 16'd4, 1, 99);
    chk("t4_words", nw, 4);
    for (int i = 0; i < 4; i++) chk("t4_data", got[i], row(48'h10 + 48'(i)));
    chk("t4_first_valid", first_n, 4);
    chk("t4_first_accept", got_n[0], 7);
    chk("t4_done", done_n, 15);
    wr(1022, row(48'h50)); wr(1023, row(48'h51)); wr(0, row(48'h52)); wr(1, row(48'h53));
    run_drain(16'd1022, 16'd4, 0, 99);
    chk("t5_words", nw, 4);
    for (int i = 0; i < 4; i++) chk("t5_wrap_data", got[i], row(48'h50 + 48'(i)));
    run_drain(16'd3, 16'd0, 0, 99);
    chk("t5_empty_done", done_n, 1);
    chk("t5_empty_novalid", first_n, -1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_empty_quiet", {drain_valid, drain_busy, drain_done}, 0);
    end
    for (int i = 0; i < 8; i++) wr(16 + i, row(48'h60 + 48'(i)));
    run_drain(16'd16, 16'd8, 0, 2);
    chk("t6_pre_words", nw, 2);
    chk("t6_pre_data0", got[0], row(48'h60));
    chk("t6_pre_data1", got[1], row(48'h61));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t6_rst_outputs", {drain_valid, drain_busy, drain_done, obuf_read_valid}, 0);
    chk("t6_rst_ddata", drain_data, '0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t6_no_done", drain_done, 0);
    end
    reset = 1'b1;
    @(negedge clk);
    run_drain(16'd16, 16'd8, 0, 99);
    chk("t6_words", nw, 8);
    for (int i = 0; i < 8; i++) chk("t6_data", got[i], row(48'h60 + 48'(i)));
    chk("t6_done", done_n, 18);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
